// File: rtl/calc_fmt_pkg.sv
// Shared types and constants for the result-formatting stages.
package calc_fmt_pkg;

    localparam int OUTPUTWIDTH     = 24;
    localparam int BCD_W           = 4;
    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
    localparam int DEF_FRAC_BITS   = 8;
    localparam int DEF_INT_DIGITS  = 5;
    localparam int DEF_FRAC_DIGITS = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_INT,
        S_FRAC,
        S_DONE
    } fmt_state_t;

endpackage

// File: rtl/fixed_to_bcd_dabble_step.sv
// One double-dabble step: +3 on every nibble >= 5, then shift left taking in bit_i.
// Combinational, zero latency; no flow control.
// Bits shifted out of the top nibble are dropped; callers size DIGITS to avoid overflow.
module dabble_step
    import calc_fmt_pkg::*;
#(
    parameter int DIGITS = DEF_INT_DIGITS
) (
    input  logic [BCD_W*DIGITS-1:0] bcd_i,
    input  logic                    bit_i,
    output logic [BCD_W*DIGITS-1:0] bcd_o
);

    logic [BCD_W*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_i[BCD_W*i +: BCD_W] >= 4'd5) begin
                adj[BCD_W*i +: BCD_W] = bcd_i[BCD_W*i +: BCD_W] + 4'd3;
            end
        end
        bcd_o = (adj << 1) | {{(BCD_W*DIGITS-1){1'b0}}, bit_i};
    end

endmodule

// File: rtl/fixed_to_bcd.sv
// Serial signed fixed-point to sign + packed BCD converter; FIXED_TO_BCD_LZ_BLANK_EN blanks leading integer zeros.
// Latency: W-FRAC+FRAC_DIGITS+2 enabled edges from i_start to the o_done pulse.
// No backpressure: i_start outside IDLE is dropped; i_ce low freezes everything.
module fixed_to_bcd
    import calc_fmt_pkg::*;
#(
    parameter int W           = OUTPUTWIDTH,
    parameter int FRAC        = DEF_FRAC_BITS,
    parameter int INT_DIGITS  = DEF_INT_DIGITS,
    parameter int FRAC_DIGITS = DEF_FRAC_DIGITS
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        i_ce,
    input  logic                        i_start,
    input  logic [W-1:0]                i_val,
    output logic                        o_sign,
    output logic [BCD_W*INT_DIGITS-1:0]  o_int_bcd,
    output logic [BCD_W*FRAC_DIGITS-1:0] o_frac_bcd,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int IW    = W - FRAC;
    localparam int BW    = BCD_W * INT_DIGITS;
    localparam int FW    = BCD_W * FRAC_DIGITS;
    localparam int CNT_W = $clog2(IW + FRAC_DIGITS + 1);

    fmt_state_t        state_q, state_d;
    logic [W-1:0]      val_q, val_d;
    logic              sign_q, sign_d;
    logic [IW-1:0]     int_sh_q, int_sh_d;
    logic [FRAC-1:0]   frac_r_q, frac_r_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [FW-1:0]     fbcd_q, fbcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              o_sign_q, o_sign_d;
    logic [BW-1:0]     o_int_q, o_int_d;
    logic [FW-1:0]     o_frac_q, o_frac_d;
    logic              o_done_q, o_done_d;

    logic [W-1:0]      mag;
    logic [FRAC+3:0]   times10;
    logic [BW-1:0]     acc_step;
    logic [BW-1:0]     int_disp;

    dabble_step #(.DIGITS(INT_DIGITS)) u_dabble (
        .bcd_i (acc_q),
        .bit_i (int_sh_q[IW-1]),
        .bcd_o (acc_step)
    );

`ifdef FIXED_TO_BCD_LZ_BLANK_EN
    logic lead;

    // The units digit is never blanked so that zero still shows as "0".
    always_comb begin
        int_disp = acc_q;
        lead     = 1'b1;
        for (int i = INT_DIGITS - 1; i >= 1; i--) begin
            if (lead && (acc_q[BCD_W*i +: BCD_W] == '0)) begin
                int_disp[BCD_W*i +: BCD_W] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign int_disp = acc_q;
`endif

    // Unsigned W-bit magnitude keeps the most negative input exact.
    assign mag     = val_q[W-1] ? (W'(0) - val_q) : val_q;
    assign times10 = ({4'b0000, frac_r_q} << 3) + ({4'b0000, frac_r_q} << 1);

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        sign_d   = sign_q;
        int_sh_d = int_sh_q;
        frac_r_d = frac_r_q;
        acc_d    = acc_q;
        fbcd_d   = fbcd_q;
        cnt_d    = cnt_q;
        o_sign_d = o_sign_q;
        o_int_d  = o_int_q;
        o_frac_d = o_frac_q;
        o_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    val_d   = i_val;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                sign_d   = val_q[W-1];
                int_sh_d = mag[W-1:FRAC];
                frac_r_d = mag[FRAC-1:0];
                acc_d    = '0;
                fbcd_d   = '0;
                cnt_d    = '0;
                state_d  = S_INT;
            end
            S_INT: begin
                acc_d    = acc_step;
                int_sh_d = {int_sh_q[IW-2:0], 1'b0};
                if (cnt_q == CNT_W'(IW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FRAC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FRAC: begin
                fbcd_d   = {fbcd_q[FW-BCD_W-1:0], times10[FRAC+3:FRAC]};
                frac_r_d = times10[FRAC-1:0];
                if (cnt_q == CNT_W'(FRAC_DIGITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                o_sign_d = sign_q;
                o_int_d  = int_disp;
                o_frac_d = fbcd_q;
                o_done_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            val_q    <= '0;
            sign_q   <= 1'b0;
            int_sh_q <= '0;
            frac_r_q <= '0;
            acc_q    <= '0;
            fbcd_q   <= '0;
            cnt_q    <= '0;
            o_sign_q <= 1'b0;
            o_int_q  <= '0;
            o_frac_q <= '0;
            o_done_q <= 1'b0;
        end else if (i_ce) begin
            state_q  <= state_d;
            val_q    <= val_d;
            sign_q   <= sign_d;
            int_sh_q <= int_sh_d;
            frac_r_q <= frac_r_d;
            acc_q    <= acc_d;
            fbcd_q   <= fbcd_d;
            cnt_q    <= cnt_d;
            o_sign_q <= o_sign_d;
            o_int_q  <= o_int_d;
            o_frac_q <= o_frac_d;
            o_done_q <= o_done_d;
        end
    end

    assign o_sign     = o_sign_q;
    assign o_int_bcd  = o_int_q;
    assign o_frac_bcd = o_frac_q;
    assign o_done     = o_done_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fixed_to_bcd.sv
// Scoreboard bench for fixed_to_bcd: directed vectors, expectations queued at start, checked on o_done.
module tb_fixed_to_bcd;

    localparam int L  = 21;
    localparam int NV = 7;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_ce;
    logic        i_start;
    logic [23:0] i_val;
    logic        o_sign;
    logic [19:0] o_int_bcd;
    logic [11:0] o_frac_bcd;
    logic        o_busy;
    logic        o_done;

    always #5 CLK = ~CLK;

    fixed_to_bcd dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_ce       (i_ce),
        .i_start    (i_start),
        .i_val      (i_val),
        .o_sign     (o_sign),
        .o_int_bcd  (o_int_bcd),
        .o_frac_bcd (o_frac_bcd),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    typedef struct {
        logic        s;
        logic [19:0] ip;
        logic [11:0] fr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [23:0] v_in [NV];
    logic        v_s  [NV];
    logic [19:0] v_ip [NV];
    logic [19:0] v_ib [NV];
    logic [11:0] v_fr [NV];

    int n_cmp   = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    bit ce_seen = 1'b0;
    bit rst_seen = 1'b0;
    bit done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        ce_seen  = i_ce;
        rst_seen = RST;
        if (i_ce && !RST) en_cnt++;
    end

    // Monitor: a new pulse appears only after an enabled edge; a pulse must hold over disabled edges.
    always @(negedge CLK) begin
        if (done_prev && !ce_seen && !rst_seen) check("done_hold", 32'(o_done), 32'd1);
        if (o_done && ce_seen && !rst_seen) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1, expected no pulse at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("sign", 32'(o_sign), 32'(mon_e.s));
                check("int_bcd", 32'(o_int_bcd), 32'(mon_e.ip));
                check("frac_bcd", 32'(o_frac_bcd), 32'(mon_e.fr));
                check("latency", 32'(en_cnt), 32'(mon_e.lat));
            end
        end
        done_prev = o_done;
    end

    task automatic start(input int idx);
        exp_t e;
        e.s  = v_s[idx];
`ifdef FIXED_TO_BCD_LZ_BLANK_EN
        e.ip = v_ib[idx];
`else
        e.ip = v_ip[idx];
`endif
        e.fr  = v_fr[idx];
        e.lat = en_cnt + 1 + L;
        sb.push_back(e);
        i_val   = v_in[idx];
        i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input bit tog);
        int k = 0;
        while (!o_done && k < 200) begin
            @(negedge CLK);
            if (tog) i_ce = ~i_ce;
            k++;
        end
        if (!o_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no o_done, expected one within 200 cycles", tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1);
    end

    initial begin
        v_in[0] = 24'hFFFD80; v_s[0] = 1'b1; v_ip[0] = 20'h00002; v_ib[0] = 20'hFFFF2; v_fr[0] = 12'h500;
        v_in[1] = 24'h0000B1; v_s[1] = 1'b0; v_ip[1] = 20'h00000; v_ib[1] = 20'hFFFF0; v_fr[1] = 12'h691;
        v_in[2] = 24'h800000; v_s[2] = 1'b1; v_ip[2] = 20'h32768; v_ib[2] = 20'h32768; v_fr[2] = 12'h000;
        v_in[3] = 24'h7FFFFF; v_s[3] = 1'b0; v_ip[3] = 20'h32767; v_ib[3] = 20'h32767; v_fr[3] = 12'h996;
        v_in[4] = 24'h000000; v_s[4] = 1'b0; v_ip[4] = 20'h00000; v_ib[4] = 20'hFFFF0; v_fr[4] = 12'h000;
        v_in[5] = 24'h3039C0; v_s[5] = 1'b0; v_ip[5] = 20'h12345; v_ib[5] = 20'h12345; v_fr[5] = 12'h750;
        v_in[6] = 24'hFFFFFF; v_s[6] = 1'b1; v_ip[6] = 20'h00000; v_ib[6] = 20'hFFFF0; v_fr[6] = 12'h003;

        RST = 1'b1; i_ce = 1'b1; i_start = 1'b0; i_val = '0;
        repeat (3) @(negedge CLK);
        check("rst_sign", 32'(o_sign), 32'd0);
        check("rst_int", 32'(o_int_bcd), 32'd0);
        check("rst_frac", 32'(o_frac_bcd), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Back-to-back: each new start is issued in the o_done cycle of the previous one.
        for (int i = 0; i < NV; i++) begin
            start(i);
            wait_done("vec", 1'b0);
        end
        @(negedge CLK);

        // Restarts while busy must be dropped.
        start(5);
        repeat (2) @(negedge CLK);
        i_val = 24'h800000; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        repeat (6) @(negedge CLK);
        i_val = 24'h7FFFFF; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        wait_done("restart", 1'b0);
        repeat (30) @(negedge CLK);
        check("held_int", 32'(o_int_bcd), 32'h12345);
        check("held_frac", 32'(o_frac_bcd), 32'h750);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Reset mid-conversion aborts it.
        start(0);
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        void'(sb.pop_back());
        check("abort_sign", 32'(o_sign), 32'd0);
        check("abort_int", 32'(o_int_bcd), 32'd0);
        check("abort_frac", 32'(o_frac_bcd), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        repeat (30) @(negedge CLK);
        start(3);
        wait_done("post_rst", 1'b0);
        @(negedge CLK);

        // Reset wins over a coincident start.
        RST = 1'b1; i_start = 1'b1; i_val = 24'h800000;
        @(negedge CLK);
        RST = 1'b0; i_start = 1'b0;
        check("rst_start_busy", 32'(o_busy), 32'd0);
        repeat (3) @(negedge CLK);
        check("rst_start_idle", 32'(o_busy), 32'd0);

        // Clock enable at 50% duty during a conversion and around the done pulse.
        start(1);
        wait_done("ce", 1'b1);
        repeat (6) begin
            @(negedge CLK);
            i_ce = ~i_ce;
        end
        i_ce = 1'b1;
        repeat (30) @(negedge CLK);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
